// File: rtl/window_seq_pkg.sv
// rtl/window_seq_pkg.sv - shared state encoding and width helpers for filter frame sequencers
package window_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_STREAM = 3'd2,
      ST_FLUSH  = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_DONE   = 3'd5
   } seq_state_t;

   // Counter width for a count range of n; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
      return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
   endfunction

endpackage

// File: rtl/frame_pos_counter.sv
// rtl/frame_pos_counter.sv - column/row position of the pixel being accepted in a frame
module frame_pos_counter
   import window_seq_pkg::*;
#(
   parameter int W = 320,
   parameter int H = 240
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                inc,
   output logic [cnt_w(W)-1:0] col,
   output logic [cnt_w(H)-1:0] row,
   output logic                last_col,
   output logic                last_pix
);

   localparam int CW = cnt_w(W);
   localparam int RW = cnt_w(H);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;

   assign last_col = (col_q == CW'(W - 1));
   assign last_pix = last_col && (row_q == RW'(H - 1));

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clr) begin
         col_d = '0;
         row_d = '0;
      end else if (inc) begin
         if (last_col) begin
            col_d = '0;
            row_d = last_pix ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign col = col_q;
   assign row = row_q;

endmodule

// File: rtl/window_frame_seq.sv
// rtl/window_frame_seq.sv - frames one source image into the 3x3 window filter with clear, flush and drain
module window_frame_seq
   import window_seq_pkg::*;
#(
   parameter int         IMAGE_WIDTH  = 320,
   parameter int         IMAGE_HEIGHT = 240,
   parameter logic [7:0] FLUSH_VALUE  = 8'd0,
   parameter int         DRAIN_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        src_valid,
   input  logic [7:0]  src_data,
   output logic        src_ready,
   output logic        flt_rst,
   output logic        flt_valid,
   output logic [7:0]  flt_data,
   input  logic        flt_out_vld,
   output logic        busy,
   output logic        frame_done,
   output logic [31:0] out_count
);

   localparam int FW = cnt_w(IMAGE_WIDTH + 2);
   localparam int DW = cnt_w(DRAIN_CYCLES + 1);

   seq_state_t    state_q, state_d;
   logic [FW-1:0] flush_q, flush_d;
   logic [DW-1:0] drain_q, drain_d;
   logic [31:0]   acc_q, acc_d;
   logic [31:0]   out_count_q, out_count_d;
   logic          flt_rst_q, flt_rst_d;
   logic          flt_valid_q, flt_valid_d;
   logic [7:0]    flt_data_q, flt_data_d;

   logic                            xfer;
   logic                            pos_clr;
   logic [cnt_w(IMAGE_WIDTH)-1:0]   pos_col;
   logic [cnt_w(IMAGE_HEIGHT)-1:0]  pos_row;
   logic                            pos_last_col;
   logic                            pos_last_pix;
   logic                            unused_pos;

   assign xfer       = src_valid && (state_q == ST_STREAM);
   assign unused_pos = ^{pos_col, pos_row, pos_last_col};

   frame_pos_counter #(
      .W (IMAGE_WIDTH),
      .H (IMAGE_HEIGHT)
   ) u_pos (
      .clk      (clk),
      .rst      (rst),
      .clr      (pos_clr),
      .inc      (xfer),
      .col      (pos_col),
      .row      (pos_row),
      .last_col (pos_last_col),
      .last_pix (pos_last_pix)
   );

   always_comb begin
      state_d     = state_q;
      flush_d     = flush_q;
      drain_d     = drain_q;
      acc_d       = acc_q;
      out_count_d = out_count_q;
      flt_rst_d   = 1'b0;
      flt_valid_d = 1'b0;
      flt_data_d  = flt_data_q;
      pos_clr     = 1'b0;

      if (state_q inside {ST_STREAM, ST_FLUSH, ST_DRAIN, ST_DONE}) begin
         acc_d = sat_inc32(acc_q, flt_out_vld);
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_CLEAR;
               flt_rst_d = 1'b1;
            end
         end
         ST_CLEAR: begin
            pos_clr = 1'b1;
            acc_d   = '0;
            state_d = ST_STREAM;
         end
         ST_STREAM: begin
            if (xfer) begin
               flt_valid_d = 1'b1;
               flt_data_d  = src_data;
               if (pos_last_pix) begin
                  state_d = ST_FLUSH;
                  flush_d = '0;
               end
            end
         end
         ST_FLUSH: begin
            flt_valid_d = 1'b1;
            flt_data_d  = FLUSH_VALUE;
            if (flush_q == FW'(IMAGE_WIDTH)) begin
               flush_d = '0;
               drain_d = '0;
               state_d = ST_DRAIN;
            end else begin
               flush_d = flush_q + FW'(1);
            end
         end
         ST_DRAIN: begin
            if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
               drain_d = '0;
               state_d = ST_DONE;
            end else begin
               drain_d = drain_q + DW'(1);
            end
         end
         ST_DONE: begin
            out_count_d = sat_inc32(acc_q, flt_out_vld);
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort leaves the filter cleared and the last completed count intact.
      if (abort && (state_q != ST_IDLE)) begin
         state_d     = ST_IDLE;
         flt_rst_d   = 1'b1;
         flt_valid_d = 1'b0;
         flush_d     = '0;
         drain_d     = '0;
         out_count_d = out_count_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         flush_q     <= '0;
         drain_q     <= '0;
         acc_q       <= '0;
         out_count_q <= '0;
         flt_rst_q   <= 1'b0;
         flt_valid_q <= 1'b0;
         flt_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         flush_q     <= flush_d;
         drain_q     <= drain_d;
         acc_q       <= acc_d;
         out_count_q <= out_count_d;
         flt_rst_q   <= flt_rst_d;
         flt_valid_q <= flt_valid_d;
         flt_data_q  <= flt_data_d;
      end
   end

   assign src_ready  = (state_q == ST_STREAM);
   assign busy       = (state_q != ST_IDLE);
   assign frame_done = (state_q == ST_DONE) && !abort;
   assign flt_rst    = flt_rst_q;
   assign flt_valid  = flt_valid_q;
   assign flt_data   = flt_data_q;
   assign out_count  = out_count_q;

endmodule

// File: tb/tb_window_frame_seq.sv
// tb/tb_window_frame_seq.sv - randomized frame-level check of window_frame_seq against a timeline model
module tb_window_frame_seq;

   localparam int         W    = 4;
   localparam int         H    = 3;
   localparam int         D    = 4;
   localparam int         NPIX = W * H;
   localparam logic [7:0] FV   = 8'd0;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic        src_valid;
   logic [7:0]  src_data;
   logic        src_ready;
   logic        flt_rst;
   logic        flt_valid;
   logic [7:0]  flt_data;
   logic        flt_out_vld;
   logic        busy;
   logic        frame_done;
   logic [31:0] out_count;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_count = 0;

   always #5 clk = ~clk;

   window_frame_seq #(
      .IMAGE_WIDTH  (W),
      .IMAGE_HEIGHT (H),
      .FLUSH_VALUE  (FV),
      .DRAIN_CYCLES (D)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .src_valid   (src_valid),
      .src_data    (src_data),
      .src_ready   (src_ready),
      .flt_rst     (flt_rst),
      .flt_valid   (flt_valid),
      .flt_data    (flt_data),
      .flt_out_vld (flt_out_vld),
      .busy        (busy),
      .frame_done  (frame_done),
      .out_count   (out_count)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_src_ready"}, src_ready, 0);
      check_eq({tag, "_flt_rst"}, flt_rst, 0);
      check_eq({tag, "_flt_valid"}, flt_valid, 0);
      check_eq({tag, "_flt_data"}, flt_data, 0);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_frame_done"}, frame_done, 0);
      check_eq({tag, "_out_count"}, out_count, 0);
   endtask

   // Expected filter beats are stamped with the cycle they must appear in:
   // a pixel one cycle after its transfer, flush beats back to back right after.
   task automatic run_frame(input int vmode, input int smode, input bit seq_pix,
                            input bit do_abort, input bit start_done, input bit skip_start);
      logic [7:0] pix [NPIX];
      int         exp_cyc[$];
      int         got_cyc[$];
      logic [7:0] exp_dat[$];
      logic [7:0] got_dat[$];
      int         idx      = 0;
      int         t_last   = -1;
      int         done_cyc = -1;
      int         strobes  = 0;
      int         nflush;
      bit         aborted  = 0;
      bit         stop     = 0;
      bit         seen     = 0;

      for (int i = 0; i < NPIX; i++) pix[i] = seq_pix ? 8'(i + 1) : 8'($urandom);
      if (!skip_start) begin
         start = 1'b1;
         tick();
         start = 1'b0;
      end
      check_eq("clear_flt_rst", flt_rst, 1);
      check_eq("clear_busy", busy, 1);

      for (int n = 0; n < 600 && !stop; n++) begin
         if (flt_valid) begin
            got_cyc.push_back(n);
            got_dat.push_back(flt_data);
         end
         if (frame_done && done_cyc < 0) done_cyc = n;
         check_eq("src_ready", src_ready, (n >= 1 && idx < NPIX) ? 1 : 0);

         case (vmode)
            0:       src_valid = 1'b1;
            1:       src_valid = ((n % 2) == 1);
            default: src_valid = ($urandom_range(0, 2) != 0);
         endcase
         src_data = (idx < NPIX) ? pix[idx] : 8'($urandom);
         if (start_done) start = (n == done_cyc) ? 1'b1 : ($urandom_range(0, 1) == 1);
         else            start = 1'b0;
         case (smode)
            0:       flt_out_vld = 1'b0;
            1:       flt_out_vld = ($urandom_range(0, 2) == 0);
            default: flt_out_vld = (n >= 1 && n <= 3) ||
                                   (t_last >= 0 && n >= t_last + W + 2 && n <= t_last + W + 4);
         endcase
         if (n >= 1 && (done_cyc < 0 || n == done_cyc)) strobes += int'(flt_out_vld);
         if (do_abort && t_last >= 0 && n == t_last + 3) begin
            abort   = 1'b1;
            aborted = 1'b1;
         end
         if (src_valid && src_ready) begin
            exp_cyc.push_back(n + 1);
            exp_dat.push_back(pix[idx]);
            idx++;
            if (idx == NPIX) begin
               t_last = n;
               nflush = do_abort ? 2 : W + 1;
               for (int j = 0; j < nflush; j++) begin
                  exp_cyc.push_back(n + 2 + j);
                  exp_dat.push_back(FV);
               end
            end
         end
         if (n == done_cyc || aborted) stop = 1'b1;
         tick();
         abort = 1'b0;
      end

      if (!start_done) start = 1'b0;
      flt_out_vld = 1'b0;
      check_eq("xfer_count", idx, NPIX);
      check_eq("beat_count", got_cyc.size(), exp_cyc.size());
      for (int i = 0; i < exp_cyc.size() && i < got_cyc.size(); i++) begin
         check_eq("beat_cycle", got_cyc[i], exp_cyc[i]);
         check_eq("beat_data", got_dat[i], exp_dat[i]);
      end

      if (do_abort) begin
         check_eq("abort_flt_rst", flt_rst, 1);
         check_eq("abort_flt_valid", flt_valid, 0);
         check_eq("abort_busy", busy, 0);
         check_eq("abort_no_done", (done_cyc < 0) ? 1 : 0, 1);
         for (int k = 0; k < 8; k++) begin
            tick();
            if (frame_done || busy || flt_valid) seen = 1'b1;
         end
         check_eq("abort_quiet", seen, 0);
         check_eq("abort_keep_count", out_count, model_count);
      end else begin
         check_eq("done_latency", done_cyc, t_last + W + 2 + D);
         model_count = strobes;
         check_eq("done_pulse", frame_done, 0);
         check_eq("idle_after_done", busy, 0);
         check_eq("no_rst_after_done", flt_rst, 0);
         check_eq("out_count", out_count, model_count);
         if (start_done) begin
            tick();
            start = 1'b0;
            check_eq("restart_flt_rst", flt_rst, 1);
            check_eq("restart_busy", busy, 1);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      abort       = 1'b0;
      src_valid   = 1'b0;
      src_data    = 8'd0;
      flt_out_vld = 1'b0;
      tick();
      check_all_zero("reset");
      tick();
      rst = 1'b0;
      tick();
      check_all_zero("post_reset");

      // Asynchronous reset in the middle of streaming.
      start = 1'b1;
      tick();
      start     = 1'b0;
      src_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         src_data    = 8'(k + 1);
         flt_out_vld = 1'b1;
         tick();
      end
      check_eq("mid_stream_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      check_all_zero("async_reset");
      src_valid   = 1'b0;
      flt_out_vld = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      check_eq("after_reset_busy", busy, 0);
      model_count = 0;
      run_frame(0, 0, 1, 0, 0, 0);

      run_frame(0, 0, 1, 0, 0, 0);
      run_frame(1, 1, 0, 0, 0, 0);

      run_frame(2, 2, 0, 0, 0, 0);
      check_eq("out_count_six", out_count, 6);
      run_frame(0, 0, 0, 0, 0, 0);

      run_frame(2, 1, 0, 0, 0, 0);
      run_frame(0, 1, 0, 1, 0, 0);

      run_frame(2, 1, 0, 0, 1, 0);
      run_frame(0, 1, 0, 0, 0, 1);

      for (int r = 0; r < 3; r++) run_frame(int'($urandom_range(0, 2)), 1, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
